// File: rtl/ariane_pkg.sv
// Memory-port types shared by the instruction cache, its line fetchers and the memory model.
package ariane_pkg;
  localparam int unsigned ICACHE_LINE_WIDTH = 128;
  localparam int unsigned PADDR_WIDTH       = 32;

  typedef struct packed {
    logic                   req;
    logic [PADDR_WIDTH-1:0] paddr;
  } mem_req_t;

  typedef struct packed {
    logic                         ready;
    logic [ICACHE_LINE_WIDTH-1:0] data;
  } mem_rsp_t;
endpackage

// File: rtl/icache_mem_arbiter.sv
// Round-robin arbiter serialising cache-line fetches from several requesters onto one memory port,
// with a programmable response latency and a one-cycle valid pulse back to the granted port.
module icache_mem_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned NR_PORTS = 2,
  parameter int unsigned LATENCY  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  mem_req_t [NR_PORTS-1:0]      req_i,
  output logic [NR_PORTS-1:0]          gnt_o,
  output logic [NR_PORTS-1:0]          rvalid_o,
  output logic [ICACHE_LINE_WIDTH-1:0] rdata_o,
  output mem_req_t                     mem_o,
  input  mem_rsp_t                     mem_i
);

  localparam int unsigned IDX_W = $clog2(NR_PORTS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [7:0] CNT_INIT = (LATENCY == 0) ? 8'd0 : 8'(LATENCY - 1);

  logic [1:0]                   state;
  logic [IDX_W-1:0]             last_grant;
  logic [IDX_W-1:0]             winner;
  logic [7:0]                   cnt;
  logic [ICACHE_LINE_WIDTH-1:0] line;
  logic                         mem_req;
  logic [PADDR_WIDTH-1:0]       mem_paddr;

  logic                         any_req;
  logic [IDX_W-1:0]             pick;

  // Walk from the farthest candidate back to last_grant+1 so the nearest requester overwrites the rest.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    for (int unsigned i = NR_PORTS; i >= 1; i--) begin
      int unsigned j;
      j = int'(last_grant) + i;
      if (j >= NR_PORTS) j = j - NR_PORTS;
      if (req_i[IDX_W'(j)].req) begin
        any_req = 1'b1;
        pick    = IDX_W'(j);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (rst_ni && (state == IDLE) && any_req) gnt_o[pick] = 1'b1;
  end

  always_comb begin
    rvalid_o = '0;
    if (state == RESP) rvalid_o[winner] = 1'b1;
  end

  assign rdata_o     = line;
  assign mem_o.req   = mem_req;
  assign mem_o.paddr = mem_paddr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NR_PORTS - 1);
      winner     <= '0;
      cnt        <= '0;
      line       <= '0;
      mem_req    <= 1'b0;
      mem_paddr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            winner     <= pick;
            last_grant <= pick;
            mem_paddr  <= req_i[pick].paddr;
            mem_req    <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // Request and address stay put until memory accepts; the line is taken only on that cycle.
          if (mem_i.ready) begin
            line    <= mem_i.data;
            mem_req <= 1'b0;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              cnt   <= CNT_INIT;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 8'd0) state <= RESP;
          else             cnt   <= cnt - 8'd1;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/icache_mem_arbiter.md
# icache_mem_arbiter

Round-robin arbiter that shares the single line-wide memory port (ariane_pkg mem_req_t/mem_rsp_t) between NR_PORTS cache-side requesters. It sits between the icache (plus prefetcher or other line fetchers) and the memory model. It serialises requests one line at a time, honours memory ready, inserts a configurable response latency so benches can emulate slow memory, and returns the captured line to the granted requester with a one-cycle valid pulse.

## Interface
- NR_PORTS, 2: number of requesters, 2..8.
- LATENCY, 2: extra cycles between memory accept and response, 0..255.
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NR_PORTS x mem_req_t  per-port request: .req, .paddr (word address).
- gnt_o  out  NR_PORTS  per-port grant; request latched this cycle.
- rvalid_o  out  NR_PORTS  per-port one-cycle response valid.
- rdata_o  out  ICACHE_LINE_WIDTH  response line, shared by all ports; qualified by rvalid_o.
- mem_o  out  mem_req_t  request to memory.
- mem_i  in  mem_rsp_t  memory response: .ready, .data (ICACHE_LINE_WIDTH).

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_i[k].req, pick winner by round-robin. The search starts at (last_grant+1) mod NR_PORTS. Assert gnt_o[winner] combinationally this cycle. Latch winner index and req_i[winner].paddr, update last_grant, go ISSUE. With no request, stay IDLE.
- ISSUE: mem_o.req=1, mem_o.paddr=latched paddr. If mem_i.ready=1, capture mem_i.data into the line register. Then go to RESP if LATENCY==0, else go to WAIT with cnt=LATENCY-1. If ready=0, hold ISSUE with req/paddr stable.
- WAIT: if cnt==0 go RESP, else cnt-=1. cnt is 8 bits.
- RESP: rvalid_o[winner]=1 for exactly this cycle, rdata_o=captured line. Go IDLE.
- A requester may drop req after its gnt; paddr need not stay stable after grant. A requester holding req after its grant is treated as a new request in the next IDLE.
- Requests arriving outside IDLE are not granted and not lost; they are arbitrated at the next IDLE.
- At most one transaction in flight. gnt_o is onehot0, and rvalid_o is onehot0.
- rdata_o holds its last captured value outside RESP.

## Timing
- Reset values: state=IDLE, last_grant=NR_PORTS-1 (so port 0 has first priority), gnt_o=0, rvalid_o=0, rdata_o=0, mem_o.req=0, mem_o.paddr=0, cnt=0.
- Reset asserted mid-transaction aborts it: no rvalid is issued, and mem_o.req drops asynchronously.
- Cycle timing, with ready=1 from memory:
  - gnt at cycle T.
  - mem_o.req at T+1.
  - rvalid at T+2+LATENCY.
  - next grant no earlier than T+3+LATENCY.
- Each cycle mem_i.ready is low in ISSUE adds one cycle to every subsequent event.
- mem_o.req and mem_o.paddr are registered outputs, driven from state and latched paddr. gnt_o is combinational from req_i and state.

## Test plan
- Single request, LATENCY=2, memory word k holds k. Port 0 requests paddr 0x10 at cycle 0 → gnt_o=01 at cycle 0; mem_o.req=1 with paddr 0x10 at cycle 1; rvalid_o=01 at cycle 4; rdata_o words = 0x10, 0x11, … up to ICACHE_LINE_WIDTH/32 words.
- Contention, NR_PORTS=2. Both ports hold req continuously from reset, port 0 at paddr 0x100 and port 1 at 0x200 → grants alternate 0,1,0,1. Each rvalid goes to the matching port with its own data (0x100… and 0x200…). Grant spacing is LATENCY+3 cycles.
- Ready stall. Hold mem_i.ready=0 for 3 cycles in ISSUE → mem_o.req/paddr stay stable throughout; rvalid is delayed by exactly 3 cycles; data is captured only on the ready cycle.
- LATENCY=0 → rvalid at grant+2, with state sequence IDLE, ISSUE, RESP, IDLE.
- Reset mid-WAIT. Deassert rst_ni during WAIT → all outputs 0 immediately; no rvalid after reset release. A new request from port 0 after release is served normally, with port 0 winning first.
- Fairness, NR_PORTS=3. All three request continuously → grant order 0,1,2,0,1,2. A late-arriving port is never skipped for more than NR_PORTS-1 grants.
